// File: rtl/aes_pkg.sv
// aes_pkg: shared AES block/word widths, pipeline latency and data types
package aes_pkg;
    localparam int AES_BLOCK_W      = 128;
    localparam int WORD_W           = 32;
    localparam int WORDS_PER_BLOCK  = 4;
    localparam int AES_PIPE_LATENCY = 11;
    typedef logic [AES_BLOCK_W-1:0] aes_block_t;
    typedef logic [WORD_W-1:0] aes_word_t;
endpackage

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo: DEPTH x 128-bit synchronous FIFO; a pop frees a full slot for a same-edge write
module aes_blk_fifo
    import aes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  aes_block_t             wdata,
    input  logic                   rd,
    output aes_block_t             head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    aes_block_t mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_wr, do_rd;
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);
    assign full  = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign head  = mem[rptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_rd) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
        end
    end
endmodule

// File: rtl/aes_cipher_drain.sv
// aes_cipher_drain: tags AES core output with a delayed launch strobe, buffers blocks, streams 32-bit words under credit control
module aes_cipher_drain
    import aes_pkg::*;
#(
    parameter int LATENCY = AES_PIPE_LATENCY,
    parameter int DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_block_t cipher_in,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_word_t  out_data,
    output logic       out_last,
    output logic       ovf_err
);
    localparam int UW = $clog2(DEPTH+1);
    logic [LATENCY-1:0] vpipe;
    logic [UW-1:0] used;
    logic [1:0] widx;
    aes_block_t head;
    logic full, empty, launch, capture, accept, pop;
    logic [$clog2(DEPTH):0] count_unused;
    assign in_ready  = used < UW'(DEPTH);
    assign launch    = in_valid && in_ready;
    assign capture   = vpipe[LATENCY-1];
    assign out_valid = !empty;
    assign out_last  = widx == 2'd3;
    assign out_data  = head[WORD_W*widx +: WORD_W];
    assign accept    = out_valid && out_ready;
    assign pop       = accept && out_last;
    aes_blk_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr    (capture),
        .wdata (cipher_in),
        .rd    (pop),
        .head  (head),
        .full  (full),
        .empty (empty),
        .count (count_unused)
    );
    // credits cover blocks still in the core, so a full FIFO at capture means upstream misbehaved
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe   <= '0;
            used    <= '0;
            widx    <= '0;
            ovf_err <= 1'b0;
        end else begin
            vpipe <= LATENCY'({vpipe, launch});
            used  <= used + UW'(launch) - UW'(pop);
            widx  <= widx + 2'(accept);
            if (capture && full && !pop) ovf_err <= 1'b1;
        end
    end
endmodule
